// File: rtl/rlwe_pkg.sv
// Shared types and helpers for the binary Ring-LWE serial engine.
// Holds the op-mode enum, FSM state encodings, the q/2 helper and the negacyclic shift.
package rlwe_pkg;

    typedef enum logic [1:0] {
        OpKeygen  = 2'd0,
        OpEncrypt = 2'd1,
        OpDecrypt = 2'd2,
        OpIllegal = 2'd3
    } op_mode_e;

    typedef logic [2:0] state_t;
    localparam state_t StIdle  = 3'd0;
    localparam state_t StLoad  = 3'd1;
    localparam state_t StMul   = 3'd2;
    localparam state_t StFinal = 3'd3;
    localparam state_t StDone  = 3'd4;

    // Widest packed polynomial the shift helper handles (N*LOGQ must stay below this).
    localparam int unsigned PolyMaxW = 1024;

    function automatic int unsigned q_half(input int unsigned logq);
        return 32'd1 << (logq - 32'd1);
    endfunction

    // Multiply a packed polynomial by x in Z_q[x]/(x^n+1): shift up one coefficient,
    // and wrap the old top coefficient into slot 0 negated.
    function automatic logic [PolyMaxW-1:0] negacyclic_shift(input logic [PolyMaxW-1:0] v,
                                                             input int unsigned n,
                                                             input int unsigned logq);
        logic [PolyMaxW-1:0] cmask;
        logic [PolyMaxW-1:0] pmask;
        logic [PolyMaxW-1:0] top;
        cmask = (PolyMaxW'(1) << logq) - PolyMaxW'(1);
        pmask = (PolyMaxW'(1) << (n * logq)) - PolyMaxW'(1);
        top   = (v >> ((n - 32'd1) * logq)) & cmask;
        return ((v << logq) & pmask) | ((~top + PolyMaxW'(1)) & cmask);
    endfunction

endpackage

// File: rtl/rlwe_mac_lane.sv
// One serial MAC lane: an N-coefficient shift register stepped by x (negacyclic) and an
// accumulator that adds the shift register whenever the current binary coefficient is 1.
module rlwe_mac_lane
    import rlwe_pkg::*;
#(
    parameter int unsigned N    = 16,
    parameter int unsigned LOGQ = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [N*LOGQ-1:0] load_sh,
    input  logic [N*LOGQ-1:0] load_acc,
    input  logic              mul_en,
    input  logic              mul_bit,
    input  logic              scrub,
    output logic [N*LOGQ-1:0] acc
);

    localparam int unsigned PW = N * LOGQ;

    logic [PW-1:0] sh_q;
    logic [PW-1:0] acc_q;
    logic [PW-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum[i*LOGQ +: LOGQ] = acc_q[i*LOGQ +: LOGQ] + sh_q[i*LOGQ +: LOGQ];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q  <= '0;
            acc_q <= '0;
        end else if (scrub) begin
            sh_q  <= '0;
            acc_q <= '0;
        end else if (load) begin
            sh_q  <= load_sh;
            acc_q <= load_acc;
        end else if (mul_en) begin
            if (mul_bit) begin
                acc_q <= sum;
            end
            sh_q <= PW'(negacyclic_shift(PolyMaxW'(sh_q), N, LOGQ));
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/rlwe_serial_engine.sv
// Binary Ring-LWE KEYGEN/ENCRYPT/DECRYPT engine with two serial negacyclic MAC lanes.
// Optional build macro RLWE_SCRUB_EN clears secrets and results when a result is consumed.
module rlwe_serial_engine
    import rlwe_pkg::*;
#(
    parameter int unsigned N    = 16,
    parameter int unsigned LOGQ = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_mode,
    input  logic [N*LOGQ-1:0] in_poly0,
    input  logic [N*LOGQ-1:0] in_poly1,
    input  logic [N-1:0]      in_bin0,
    input  logic [N-1:0]      in_bin1,
    input  logic [N-1:0]      in_bin2,
    input  logic [N-1:0]      in_msg,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N*LOGQ-1:0] res_poly0,
    output logic [N*LOGQ-1:0] res_poly1,
    output logic [N-1:0]      res_msg,
    output logic              res_err
);

    localparam int unsigned PW = N * LOGQ;
    localparam int unsigned CW = $clog2(N);
    localparam logic [LOGQ-1:0] QHalf = LOGQ'(q_half(LOGQ));

    state_t        state_q;
    op_mode_e      mode_q;
    logic [N-1:0]  b0_q, b1_q, b2_q, msg_q;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] acc0, acc1, fin0, fin1;
    logic [N-1:0]  fin_msg;
    logic [LOGQ-1:0] dec_v;
    logic          accept, legal, retire, scrub, is_enc, is_dec;

    assign op_ready = (state_q == StIdle);
    assign accept   = op_valid && op_ready;
    assign legal    = (op_mode != OpIllegal);
    assign retire   = (state_q == StDone) && res_ready;
    assign is_enc   = (op_mode == OpEncrypt);
    assign is_dec   = (op_mode == OpDecrypt);
`ifdef RLWE_SCRUB_EN
    assign scrub = retire;
`else
    assign scrub = 1'b0;
`endif

    // DECRYPT seeds lane0's accumulator with c2, so v = c2 + c1*r2 falls out of the MAC.
    rlwe_mac_lane #(.N(N), .LOGQ(LOGQ)) u_lane0 (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && legal),
        .load_sh  (in_poly0),
        .load_acc (is_dec ? in_poly1 : '0),
        .mul_en   (state_q == StMul),
        .mul_bit  (b0_q[0]),
        .scrub    (scrub),
        .acc      (acc0)
    );

    rlwe_mac_lane #(.N(N), .LOGQ(LOGQ)) u_lane1 (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && legal),
        .load_sh  (is_enc ? in_poly1 : '0),
        .load_acc ('0),
        .mul_en   (state_q == StMul),
        .mul_bit  (b0_q[0]),
        .scrub    (scrub),
        .acc      (acc1)
    );

    always_comb begin
        fin0    = '0;
        fin1    = '0;
        fin_msg = '0;
        dec_v   = '0;
        for (int i = 0; i < N; i++) begin
            unique case (mode_q)
                OpKeygen: begin
                    fin0[i*LOGQ +: LOGQ] = LOGQ'(b1_q[i]) - acc0[i*LOGQ +: LOGQ];
                end
                OpEncrypt: begin
                    fin0[i*LOGQ +: LOGQ] = acc0[i*LOGQ +: LOGQ] + LOGQ'(b1_q[i]);
                    fin1[i*LOGQ +: LOGQ] = acc1[i*LOGQ +: LOGQ] + LOGQ'(b2_q[i])
                                           + (msg_q[i] ? QHalf : '0);
                end
                OpDecrypt: begin
                    dec_v      = acc0[i*LOGQ +: LOGQ];
                    fin_msg[i] = dec_v[LOGQ-1] ^ dec_v[LOGQ-2];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            mode_q    <= OpKeygen;
            b0_q      <= '0;
            b1_q      <= '0;
            b2_q      <= '0;
            msg_q     <= '0;
            cnt_q     <= '0;
            res_valid <= 1'b0;
            res_poly0 <= '0;
            res_poly1 <= '0;
            res_msg   <= '0;
            res_err   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (op_valid) begin
                        mode_q <= op_mode_e'(op_mode);
                        b0_q   <= in_bin0;
                        b1_q   <= in_bin1;
                        b2_q   <= in_bin2;
                        msg_q  <= in_msg;
                        cnt_q  <= '0;
                        if (legal) begin
                            state_q <= StLoad;
                        end else begin
                            state_q   <= StDone;
                            res_valid <= 1'b1;
                            res_err   <= 1'b1;
                            res_poly0 <= '0;
                            res_poly1 <= '0;
                            res_msg   <= '0;
                        end
                    end
                end
                StLoad: begin
                    cnt_q   <= '0;
                    state_q <= StMul;
                end
                StMul: begin
                    b0_q  <= b0_q >> 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_q <= StFinal;
                    end
                end
                StFinal: begin
                    res_poly0 <= fin0;
                    res_poly1 <= fin1;
                    res_msg   <= fin_msg;
                    res_err   <= 1'b0;
                    res_valid <= 1'b1;
                    state_q   <= StDone;
                end
                StDone: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_q   <= StIdle;
`ifdef RLWE_SCRUB_EN
                        res_poly0 <= '0;
                        res_poly1 <= '0;
                        res_msg   <= '0;
                        res_err   <= 1'b0;
                        b1_q      <= '0;
                        b2_q      <= '0;
                        msg_q     <= '0;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rlwe_serial_engine.sv
// Directed bench for rlwe_serial_engine: small N=4/LOGQ=4 instance for hand-computed vectors,
// default-size instance for randomised KEYGEN->ENCRYPT->DECRYPT round trips.
module tb_rlwe_serial_engine;

    logic clk, rst;
    int   checks = 0;
    int   errors = 0;

    // Small instance, N=4 LOGQ=4
    logic        s_op_valid, s_op_ready, s_res_valid, s_res_ready, s_res_err;
    logic [1:0]  s_op_mode;
    logic [15:0] s_in_poly0, s_in_poly1, s_res_poly0, s_res_poly1;
    logic [3:0]  s_in_bin0, s_in_bin1, s_in_bin2, s_in_msg, s_res_msg;

    // Default instance, N=16 LOGQ=8
    logic         b_op_valid, b_op_ready, b_res_valid, b_res_ready, b_res_err;
    logic [1:0]   b_op_mode;
    logic [127:0] b_in_poly0, b_in_poly1, b_res_poly0, b_res_poly1;
    logic [15:0]  b_in_bin0, b_in_bin1, b_in_bin2, b_in_msg, b_res_msg;

    rlwe_serial_engine #(.N(4), .LOGQ(4)) u_small (
        .clk(clk), .rst(rst), .op_valid(s_op_valid), .op_ready(s_op_ready),
        .op_mode(s_op_mode), .in_poly0(s_in_poly0), .in_poly1(s_in_poly1),
        .in_bin0(s_in_bin0), .in_bin1(s_in_bin1), .in_bin2(s_in_bin2), .in_msg(s_in_msg),
        .res_valid(s_res_valid), .res_ready(s_res_ready), .res_poly0(s_res_poly0),
        .res_poly1(s_res_poly1), .res_msg(s_res_msg), .res_err(s_res_err)
    );

    rlwe_serial_engine u_big (
        .clk(clk), .rst(rst), .op_valid(b_op_valid), .op_ready(b_op_ready),
        .op_mode(b_op_mode), .in_poly0(b_in_poly0), .in_poly1(b_in_poly1),
        .in_bin0(b_in_bin0), .in_bin1(b_in_bin1), .in_bin2(b_in_bin2), .in_msg(b_in_msg),
        .res_valid(b_res_valid), .res_ready(b_res_ready), .res_poly0(b_res_poly0),
        .res_poly1(b_res_poly1), .res_msg(b_res_msg), .res_err(b_res_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pack4(input int c0, input int c1, input int c2, input int c3);
        return {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
    endfunction

    // Issue one op on the small DUT and return cycles from accept edge to res_valid.
    task automatic s_op(input logic [1:0] mode, input logic [15:0] p0, input logic [15:0] p1,
                        input logic [3:0] b0, input logic [3:0] b1, input logic [3:0] b2,
                        input logic [3:0] m, output int lat);
        int t = 0;
        while (!s_op_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        s_op_mode = mode; s_in_poly0 = p0; s_in_poly1 = p1;
        s_in_bin0 = b0; s_in_bin1 = b1; s_in_bin2 = b2; s_in_msg = m;
        s_op_valid = 1'b1;
        @(posedge clk); #1;
        s_op_valid = 1'b0;
        // Scramble inputs after accept; the engine must ignore them.
        s_in_poly0 = ~p0; s_in_poly1 = ~p1; s_in_bin0 = ~b0; s_in_bin1 = ~b1;
        s_in_bin2 = ~b2; s_in_msg = ~m; s_op_mode = 2'd0;
        lat = 0;
        while (!s_res_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic s_ack();
        s_res_ready = 1'b1;
        @(posedge clk); #1;
        s_res_ready = 1'b0;
    endtask

    task automatic b_op(input logic [1:0] mode, input logic [127:0] p0, input logic [127:0] p1,
                        input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2,
                        input logic [15:0] m, output int lat);
        int t = 0;
        while (!b_op_ready && t < 80) begin
            @(posedge clk); #1; t++;
        end
        b_op_mode = mode; b_in_poly0 = p0; b_in_poly1 = p1;
        b_in_bin0 = b0; b_in_bin1 = b1; b_in_bin2 = b2; b_in_msg = m;
        b_op_valid = 1'b1;
        @(posedge clk); #1;
        b_op_valid = 1'b0;
        lat = 0;
        while (!b_res_valid && lat < 80) begin
            @(posedge clk); #1; lat++;
        end
        b_res_ready = 1'b1;
    endtask

    task automatic b_ack();
        @(posedge clk); #1;
        b_res_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [127:0] a, p, c1, c2;
        logic [15:0]  r1, r2, e1, e2, e3, m;

        rst = 1'b1;
        s_op_valid = 1'b0; s_res_ready = 1'b0; s_op_mode = 2'd0;
        s_in_poly0 = '0; s_in_poly1 = '0; s_in_bin0 = '0; s_in_bin1 = '0;
        s_in_bin2 = '0; s_in_msg = '0;
        b_op_valid = 1'b0; b_res_ready = 1'b0; b_op_mode = 2'd0;
        b_in_poly0 = '0; b_in_poly1 = '0; b_in_bin0 = '0; b_in_bin1 = '0;
        b_in_bin2 = '0; b_in_msg = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_op_ready", 64'(s_op_ready), 64'd1);
        check("rst_res_valid", 64'(s_res_valid), 64'd0);
        check("rst_res_poly0", 64'(s_res_poly0), 64'd0);
        check("rst_res_poly1", 64'(s_res_poly1), 64'd0);
        check("rst_res_msg", 64'(s_res_msg), 64'd0);
        check("rst_res_err", 64'(s_res_err), 64'd0);
        check("rst_big_ready", 64'(b_op_ready), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // KEYGEN: a=[1,2,3,4], r2=x, r1=0 -> p = -(a*x) = [4,15,14,13]
        s_op(2'd0, pack4(1, 2, 3, 4), 16'hffff, 4'b0010, 4'b0000, 4'b1111, 4'b1111, lat);
        check("kg_latency", 64'(lat), 64'd6);
        check("kg_poly0", 64'(s_res_poly0), 64'(pack4(4, 15, 14, 13)));
        check("kg_poly1", 64'(s_res_poly1), 64'd0);
        check("kg_msg", 64'(s_res_msg), 64'd0);
        check("kg_err", 64'(s_res_err), 64'd0);
        check("kg_busy", 64'(s_op_ready), 64'd0);
        s_ack();
        check("kg_ready_after", 64'(s_op_ready), 64'd1);
        check("kg_valid_after", 64'(s_res_valid), 64'd0);

        // ENCRYPT with zero noise: c1 = 0, c2 = 8*m
        s_op(2'd1, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4'b0000, 4'b0000, 4'b0000, 4'b0101,
             lat);
        check("enc0_latency", 64'(lat), 64'd6);
        check("enc0_poly0", 64'(s_res_poly0), 64'd0);
        check("enc0_poly1", 64'(s_res_poly1), 64'(pack4(8, 0, 8, 0)));
        check("enc0_msg", 64'(s_res_msg), 64'd0);
        s_ack();

        // ENCRYPT: e1=1+x, e2=1, e3=x^3, m=x -> c1=[14,3,5,7], c2=[13,3,13,0]
        s_op(2'd1, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4'b0011, 4'b0001, 4'b1000, 4'b0010,
             lat);
        check("enc1_poly0", 64'(s_res_poly0), 64'(pack4(14, 3, 5, 7)));
        check("enc1_poly1", 64'(s_res_poly1), 64'(pack4(13, 3, 13, 0)));
        // Back-pressure: hold the result for 10 cycles
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("stall_valid", 64'(s_res_valid), 64'd1);
            check("stall_ready", 64'(s_op_ready), 64'd0);
            check("stall_poly0", 64'(s_res_poly0), 64'(pack4(14, 3, 5, 7)));
            check("stall_poly1", 64'(s_res_poly1), 64'(pack4(13, 3, 13, 0)));
        end
        s_ack();
        check("stall_done", 64'(s_op_ready), 64'd1);

        // DECRYPT: v = c1*x^2 + c2 = [8,12,11,3] -> bits 0101
        s_op(2'd2, pack4(14, 3, 5, 7), pack4(13, 3, 13, 0), 4'b0100, 4'b1111, 4'b1111, 4'b1111,
             lat);
        check("dec_latency", 64'(lat), 64'd6);
        check("dec_msg", 64'(s_res_msg), 64'b0101);
        check("dec_poly0", 64'(s_res_poly0), 64'd0);
        check("dec_poly1", 64'(s_res_poly1), 64'd0);
        s_ack();

        // Illegal mode
        s_op(2'd3, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4'b1111, 4'b1111, 4'b1111, 4'b1111,
             lat);
        check("ill_latency", 64'(lat), 64'd0);
        check("ill_err", 64'(s_res_err), 64'd1);
        check("ill_poly0", 64'(s_res_poly0), 64'd0);
        check("ill_poly1", 64'(s_res_poly1), 64'd0);
        check("ill_msg", 64'(s_res_msg), 64'd0);
        s_ack();

        // Reset three cycles into MUL
        s_op_mode = 2'd1; s_in_poly0 = pack4(1, 2, 3, 4); s_in_poly1 = pack4(5, 6, 7, 8);
        s_in_bin0 = 4'b0011; s_in_bin1 = 4'b0001; s_in_bin2 = 4'b1000; s_in_msg = 4'b0010;
        s_op_valid = 1'b1;
        @(posedge clk); #1;
        s_op_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mrst_valid", 64'(s_res_valid), 64'd0);
        check("mrst_err", 64'(s_res_err), 64'd0);
        check("mrst_poly0", 64'(s_res_poly0), 64'd0);
        check("mrst_poly1", 64'(s_res_poly1), 64'd0);
        check("mrst_msg", 64'(s_res_msg), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("mrst_ready", 64'(s_op_ready), 64'd1);
        s_op(2'd1, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4'b0011, 4'b0001, 4'b1000, 4'b0010,
             lat);
        check("mrst_next_lat", 64'(lat), 64'd6);
        check("mrst_next_poly0", 64'(s_res_poly0), 64'(pack4(14, 3, 5, 7)));
        check("mrst_next_poly1", 64'(s_res_poly1), 64'(pack4(13, 3, 13, 0)));
        s_ack();

        // Random round trips on the default-size instance
        for (int it = 0; it < 1000; it++) begin
            a  = {$urandom(), $urandom(), $urandom(), $urandom()};
            r1 = 16'($urandom()); r2 = 16'($urandom());
            e1 = 16'($urandom()); e2 = 16'($urandom()); e3 = 16'($urandom());
            m  = 16'($urandom());
            b_op(2'd0, a, '0, r2, r1, '0, '0, lat);
            check("rt_kg_latency", 64'(lat), 64'd18);
            p = b_res_poly0;
            b_ack();
            b_op(2'd1, a, p, e1, e2, e3, m, lat);
            c1 = b_res_poly0;
            c2 = b_res_poly1;
            b_ack();
            b_op(2'd2, c1, c2, r2, '0, '0, '0, lat);
            check("rt_msg", 64'(b_res_msg), 64'(m));
            b_ack();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
